// File: rtl/ext_pkg.sv
// Shared definitions for the decode-stage immediate extender: op codes,
// occupancy states and width sanity checks.
package ext_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] EXT_ZERO  = 4'd0;
    localparam logic [OP_W-1:0] EXT_SIGN  = 4'd1;
    localparam logic [OP_W-1:0] EXT_LUI   = 4'd2;
    localparam logic [OP_W-1:0] EXT_BR    = 4'd3;
    localparam logic [OP_W-1:0] EXT_JMP   = 4'd4;
    localparam logic [OP_W-1:0] EXT_SIGN2 = 4'd5;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_IMM_W  = 16;
    localparam int unsigned DEF_J_W    = 26;

    // Buffer occupancy: main entry drives the outputs, skid absorbs one stall
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

    // JMP needs room for the upper PC bits; LUI needs room for imm16 << IMM_W
    function automatic bit widths_ok(int unsigned data_w, int unsigned imm_w, int unsigned j_w);
        return (data_w >= j_w + 3) && (data_w >= 2 * imm_w);
    endfunction

endpackage

// File: rtl/d_ext_core.sv
// Combinational op decode and arithmetic for the immediate extender.
// Optional error output guarded by D_EXT_STAGE_ERR_EN.
module d_ext_core
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IMM_W  = DEF_IMM_W,
    parameter int unsigned J_W    = DEF_J_W
) (
    input  logic [IMM_W-1:0]  i_imm16,
    input  logic [J_W-1:0]    i_imm26,
    input  logic [OP_W-1:0]   i_ext_op,
    input  logic [DATA_W-1:0] i_pc,
`ifdef D_EXT_STAGE_ERR_EN
    output logic              o_err_c,
`endif
    output logic [DATA_W-1:0] o_res_c
);

    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_pc4;

    assign w_sext = {{(DATA_W-IMM_W){i_imm16[IMM_W-1]}}, i_imm16};
    assign w_pc4  = i_pc + DATA_W'(4);

    // Select the extended immediate / target; undefined codes give zero
    always_comb begin
        o_res_c = '0;
        case (i_ext_op)
            EXT_ZERO:  o_res_c = DATA_W'(i_imm16);
            EXT_SIGN:  o_res_c = w_sext;
            EXT_LUI:   o_res_c = DATA_W'(i_imm16) << IMM_W;
            EXT_BR:    o_res_c = w_pc4 + (w_sext << 2);
            EXT_JMP:   o_res_c = {w_pc4[DATA_W-1:J_W+2], i_imm26, 2'b00};
            EXT_SIGN2: o_res_c = w_sext << 2;
            default:   o_res_c = '0;
        endcase
    end

`ifdef D_EXT_STAGE_ERR_EN
    assign o_err_c = (i_ext_op > EXT_SIGN2);
`endif

endmodule

// File: rtl/d_ext_stage.sv
// Registered valid/ready immediate-extend stage with a two-entry skid buffer.
// Define D_EXT_STAGE_ERR_EN to add the ext_err output and its storage.
module d_ext_stage
    import ext_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IMM_W  = DEF_IMM_W,
    parameter int unsigned J_W    = DEF_J_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm16,
    input  logic [J_W-1:0]    imm26,
    input  logic [OP_W-1:0]   ext_op,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef D_EXT_STAGE_ERR_EN
    output logic              ext_err,
`endif
    output logic [DATA_W-1:0] ext_imm
);

    if (!widths_ok(DATA_W, IMM_W, J_W)) begin : g_bad_widths
        $error("d_ext_stage: DATA_W too small for IMM_W/J_W");
    end

`ifdef D_EXT_STAGE_ERR_EN
    localparam int unsigned ENT_W = DATA_W + 1;
`else
    localparam int unsigned ENT_W = DATA_W;
`endif

    occ_state_t        r_state;
    logic [ENT_W-1:0]  r_main;
    logic [ENT_W-1:0]  r_skid;
    logic              r_out_valid;
    logic              r_in_ready;

    logic [DATA_W-1:0] w_res;
    logic [ENT_W-1:0]  w_ent;
    logic              w_acc;
    logic              w_dlv;

`ifdef D_EXT_STAGE_ERR_EN
    logic              w_err;

    d_ext_core #(.DATA_W(DATA_W), .IMM_W(IMM_W), .J_W(J_W)) u_core (
        .i_imm16  (imm16),
        .i_imm26  (imm26),
        .i_ext_op (ext_op),
        .i_pc     (pc),
        .o_err_c  (w_err),
        .o_res_c  (w_res)
    );

    assign w_ent   = {w_err, w_res};
    assign ext_err = r_main[DATA_W];
`else
    d_ext_core #(.DATA_W(DATA_W), .IMM_W(IMM_W), .J_W(J_W)) u_core (
        .i_imm16  (imm16),
        .i_imm26  (imm26),
        .i_ext_op (ext_op),
        .i_pc     (pc),
        .o_res_c  (w_res)
    );

    assign w_ent = w_res;
`endif

    assign w_acc     = in_valid & r_in_ready;
    assign w_dlv     = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ext_imm   = r_main[DATA_W-1:0];

    // Occupancy FSM; in_ready/out_valid are registered copies of the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main      <= w_ent;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && !w_dlv) begin
                        r_skid     <= w_ent;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_acc && w_dlv) begin
                        r_main <= w_ent;
                    end else if (w_dlv) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_dlv) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_ext_stage.sv
// Directed self-checking bench for d_ext_stage.
module tb_d_ext_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [3:0]  ext_op;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_imm;
`ifdef D_EXT_STAGE_ERR_EN
    logic        ext_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    d_ext_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm16     (imm16),
        .imm26     (imm26),
        .ext_op    (ext_op),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef D_EXT_STAGE_ERR_EN
        .ext_err   (ext_err),
`endif
        .ext_imm   (ext_imm)
    );

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] p);
        in_valid = v;
        ext_op   = op;
        imm16    = i16;
        imm26    = i26;
        pc       = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 26'h0, 32'h0);
        #12;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_tests++;
        if (ext_imm !== 32'h0) begin n_fail++; $display("FAIL reset_ext_imm got %h want 00000000", ext_imm); end
`ifdef D_EXT_STAGE_ERR_EN
        n_tests++;
        if (ext_err !== 1'b0) begin n_fail++; $display("FAIL reset_ext_err got %0b want 0", ext_err); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    // Back-to-back ops with out_ready high: each result visible one cycle after accept
    task automatic test_ops();
        logic [3:0]  ops  [8];
        logic [15:0] i16s [8];
        logic [25:0] i26s [8];
        logic [31:0] pcs  [8];
        logic [31:0] exps [8];
        logic        errs [8];
        ops[0] = 4'd0; i16s[0] = 16'h8001; i26s[0] = 26'h0; pcs[0] = 32'h0;        exps[0] = 32'h0000_8001; errs[0] = 1'b0;
        ops[1] = 4'd1; i16s[1] = 16'h8001; i26s[1] = 26'h0; pcs[1] = 32'h0;        exps[1] = 32'hFFFF_8001; errs[1] = 1'b0;
        ops[2] = 4'd2; i16s[2] = 16'h8001; i26s[2] = 26'h0; pcs[2] = 32'h0;        exps[2] = 32'h8001_0000; errs[2] = 1'b0;
        ops[3] = 4'd3; i16s[3] = 16'hFFFF; i26s[3] = 26'h0; pcs[3] = 32'h0000_3000; exps[3] = 32'h0000_3000; errs[3] = 1'b0;
        ops[4] = 4'd4; i16s[4] = 16'h0;    i26s[4] = 26'h1; pcs[4] = 32'hF000_0000; exps[4] = 32'hF000_0004; errs[4] = 1'b0;
        ops[5] = 4'd5; i16s[5] = 16'h8001; i26s[5] = 26'h0; pcs[5] = 32'h0;        exps[5] = 32'hFFFE_0004; errs[5] = 1'b0;
        ops[6] = 4'd9; i16s[6] = 16'h1234; i26s[6] = 26'h5; pcs[6] = 32'h100;      exps[6] = 32'h0000_0000; errs[6] = 1'b1;
        ops[7] = 4'd3; i16s[7] = 16'h0;    i26s[7] = 26'h0; pcs[7] = 32'hFFFF_FFFC; exps[7] = 32'h0000_0000; errs[7] = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ops[i], i16s[i], i26s[i], pcs[i]);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || ext_imm !== exps[i]) begin
                n_fail++;
                $display("FAIL op%0d code %0d got valid=%0b imm=%h want valid=1 imm=%h", i, ops[i], out_valid, ext_imm, exps[i]);
            end
            n_tests++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL op%0d_in_ready got %0b want 1", i, in_ready); end
`ifdef D_EXT_STAGE_ERR_EN
            n_tests++;
            if (ext_err !== errs[i]) begin n_fail++; $display("FAIL op%0d_err got %0b want %0b", i, ext_err, errs[i]); end
`endif
        end
        drive(1'b0, 4'd0, 16'h0, 26'h0, 32'h0);
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ops_drain got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 16'h1111, 26'h0, 32'h0);
        step();
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || ext_imm !== 32'h1111)
            begin n_fail++; $display("FAIL bp_first got v=%0b r=%0b imm=%h want v=1 r=1 imm=00001111", out_valid, in_ready, ext_imm); end
        drive(1'b1, 4'd0, 16'h2222, 26'h0, 32'h0);
        step();
        n_tests++;
        if (in_ready !== 1'b0 || ext_imm !== 32'h1111)
            begin n_fail++; $display("FAIL bp_full got r=%0b imm=%h want r=0 imm=00001111", in_ready, ext_imm); end
        drive(1'b1, 4'd0, 16'h3333, 26'h0, 32'h0);
        step();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || ext_imm !== 32'h1111)
            begin n_fail++; $display("FAIL bp_hold got v=%0b r=%0b imm=%h want v=1 r=0 imm=00001111", out_valid, in_ready, ext_imm); end
        out_ready = 1'b1;
        step();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || ext_imm !== 32'h2222)
            begin n_fail++; $display("FAIL bp_second got v=%0b r=%0b imm=%h want v=1 r=1 imm=00002222", out_valid, in_ready, ext_imm); end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || ext_imm !== 32'h3333)
            begin n_fail++; $display("FAIL bp_third got v=%0b imm=%h want v=1 imm=00003333", out_valid, ext_imm); end
        drive(1'b0, 4'd0, 16'h0, 26'h0, 32'h0);
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got v=%0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 16'h00AA, 26'h0, 32'h0);
        step();
        step();
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_setup got r=%0b want 0", in_ready); end
        out_ready = 1'b1;
        drive(1'b1, 4'd0, 16'h00BB, 26'h0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL flush_state got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); end
        drive(1'b0, 4'd0, 16'h0, 26'h0, 32'h0);
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got v=%0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 16'hFFFF, 26'h0, 32'h0);
        step();
        step();
        drive(1'b0, 4'd0, 16'h0, 26'h0, 32'h0);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || ext_imm !== 32'hFFFF_FFFF)
            begin n_fail++; $display("FAIL rst_setup got v=%0b r=%0b imm=%h want v=1 r=0 imm=ffffffff", out_valid, in_ready, ext_imm); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ext_imm !== 32'h0)
            begin n_fail++; $display("FAIL rst_async got v=%0b r=%0b imm=%h want v=0 r=1 imm=00000000", out_valid, in_ready, ext_imm); end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after got v=%0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
